// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types; instruction-cache address split and FSM states.
package cpu_types_pkg;
  localparam int IIDX_W = 4;
  localparam int ITAG_W = 26;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} icache_state_t;
endpackage

// File: rtl/icache_if.sv
// Fetch-side request/response and memory-controller instruction port of the icache.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave  (input  imemREN, imemaddr, iwait, iload,
                  output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iwait, iload,
                  input  ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: combinational hits, blocking
// single-word fill through the memory controller on a miss.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     cif,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  logic [NSETS-1:0] valid;
  logic [TW-1:0]    tags [NSETS];
  logic [31:0]      data [NSETS];
  logic [29:0]      miss_addr;
  icache_state_t    state, state_n;

  logic [IW-1:0] idx, midx;
  logic [TW-1:0] tag, mtag;
  logic          hit, miss_start, fill;
  logic          unused_boff;

  assign idx  = cif.imemaddr[IW+1:2];
  assign tag  = cif.imemaddr[31:IW+2];
  assign midx = miss_addr[IW-1:0];
  assign mtag = miss_addr[29:IW];
  assign unused_boff = ^cif.imemaddr[1:0];

  assign hit          = valid[idx] && (tags[idx] == tag);
  assign cif.imemload = data[idx];
  assign cif.iaddr    = {miss_addr, 2'b00};

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n    = state;
    cif.ihit   = 1'b0;
    cif.iREN   = 1'b0;
    miss_start = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: if (cif.imemREN) begin
        if (hit) cif.ihit = 1'b1;
        else begin
          miss_start = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        cif.iREN = 1'b1;
        if (!cif.iwait) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Valid bits and the miss address are reset; the frame store is not.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      if (miss_start) miss_addr  <= cif.imemaddr[31:2];
      if (fill)       valid[midx] <= 1'b1;
    end

  always_ff @(posedge CLK)
    if (fill) begin
      data[midx] <= cif.iload;
      tags[midx] <= mtag;
    end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (cif.ihit && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run
// against a frame-table reference model.
module tb_icache;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] hit_count, miss_count;
  int          checks = 0;
  int          errors = 0;

  icache_if bus();
  icache #(.NSETS(16)) dut (.CLK(CLK), .nRST(nRST), .cif(bus),
                            .hit_count(hit_count), .miss_count(miss_count));

  always #5 CLK = ~CLK;

  // reference model: frame table plus a pending-fill flag
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_busy;
  logic [31:0] m_paddr;
  logic [31:0] m_hits, m_miss;

  // expected/actual snapshot of the most recent step
  logic        e_hit, e_iren, a_hit, a_iren;
  logic [31:0] e_load, e_iaddr, a_load, a_iaddr, a_hc, a_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_busy = 0; m_paddr = 0; m_hits = 0; m_miss = 0;
  endtask

  // Drive one cycle: apply inputs at negedge, snapshot outputs, advance model on posedge.
  task automatic step(input logic ren, input logic [31:0] a, input logic wt, input logic [31:0] ld);
    int i;
    @(negedge CLK);
    bus.imemREN = ren; bus.imemaddr = a; bus.iwait = wt; bus.iload = ld;
    #1;
    i       = int'(a[5:2]);
    e_hit   = !m_busy && ren && m_valid[i] && (m_tag[i] == a[31:6]);
    e_load  = m_data[i];
    e_iren  = m_busy;
    e_iaddr = m_paddr;
    a_hit = bus.ihit; a_load = bus.imemload; a_iren = bus.iREN; a_iaddr = bus.iaddr;
    a_hc = hit_count; a_mc = miss_count;
    @(posedge CLK);
    if (m_busy) begin
      if (!wt) begin
        i = int'(m_paddr[5:2]);
        m_valid[i] = 1; m_tag[i] = m_paddr[31:6]; m_data[i] = ld; m_busy = 0;
      end
    end else if (ren && !e_hit) begin
      m_busy = 1; m_paddr = {a[31:2], 2'b00};
      if (m_miss != 32'hFFFF_FFFF) m_miss++;
    end
    if (e_hit && m_hits != 32'hFFFF_FFFF) m_hits++;
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.imemREN = 0; bus.imemaddr = 0; bus.iwait = 1; bus.iload = 0;
    model_reset();
    #3;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got %b want 0", bus.ihit); end
    checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL reset_iren got %b want 0", bus.iREN); end
    checks++; if (bus.iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h want 0", bus.iaddr); end
    checks++; if (hit_count !== 0 || miss_count !== 0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_cold_miss();
    step(1, 32'h0, 1, 0);
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL cold_first_hit got %b want 0", a_hit); end
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h0, (k < 3), 32'h2002_0001);
      checks++; if (a_iren !== 1'b1 || a_iaddr !== 32'h0 || a_hit !== 1'b0) begin errors++;
        $display("FAIL cold_fetch%0d iren=%b iaddr=%h ihit=%b want 1/0/0", k, a_iren, a_iaddr, a_hit); end
    end
    step(1, 32'h0, 1, 0);
    checks++; if (a_hit !== 1'b1 || a_load !== 32'h2002_0001) begin errors++;
      $display("FAIL cold_hit ihit=%b load=%h want 1/20020001", a_hit, a_load); end
    checks++; if (a_mc !== 32'd1) begin errors++; $display("FAIL cold_miss_count got %0d want 1", a_mc); end
  endtask

  task automatic test_repeat_hit();
    logic [31:0] h0;
    h0 = m_hits;
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h0, 1, 0);
      checks++; if (a_hit !== 1'b1 || a_iren !== 1'b0 || a_load !== 32'h2002_0001) begin errors++;
        $display("FAIL repeat_hit%0d ihit=%b iren=%b load=%h", k, a_hit, a_iren, a_load); end
    end
    step(0, 32'h0, 1, 0);
    checks++; if (a_hc !== h0 + 32'd5 || a_hc !== m_hits) begin errors++;
      $display("FAIL repeat_hit_count got %0d want %0d", a_hc, h0 + 32'd5); end
  endtask

  task automatic test_eviction();
    step(1, 32'h40, 1, 0);
    step(1, 32'h40, 0, 32'hDEAD_BEEF);
    checks++; if (a_iaddr !== 32'h40) begin errors++; $display("FAIL evict_iaddr got %h want 40", a_iaddr); end
    step(1, 32'h40, 1, 0);
    checks++; if (a_hit !== 1'b1 || a_load !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL evict_hit ihit=%b load=%h want 1/deadbeef", a_hit, a_load); end
    step(1, 32'h0, 1, 0);
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL evict_old_miss ihit=%b want 0", a_hit); end
    step(1, 32'h0, 0, 32'h2002_0001);
    checks++; if (a_iren !== 1'b1 || a_iaddr !== 32'h0) begin errors++;
      $display("FAIL evict_refill iren=%b iaddr=%h want 1/0", a_iren, a_iaddr); end
  endtask

  task automatic test_req_change();
    step(1, 32'h4, 1, 0);
    step(1, 32'h8, 1, 0);
    checks++; if (a_iaddr !== 32'h4) begin errors++; $display("FAIL chg_iaddr_a got %h want 4", a_iaddr); end
    step(0, 32'h8, 1, 0);
    checks++; if (a_iaddr !== 32'h4 || a_hit !== 1'b0) begin errors++;
      $display("FAIL chg_iaddr_b iaddr=%h ihit=%b want 4/0", a_iaddr, a_hit); end
    step(0, 32'h8, 0, 32'h1111_2222);
    checks++; if (a_iaddr !== 32'h4 || a_iren !== 1'b1) begin errors++;
      $display("FAIL chg_complete iaddr=%h iren=%b want 4/1", a_iaddr, a_iren); end
    step(0, 32'h4, 1, 0);
    checks++; if (a_hit !== 1'b0 || a_iren !== 1'b0) begin errors++;
      $display("FAIL chg_idle ihit=%b iren=%b want 0/0", a_hit, a_iren); end
    step(1, 32'h4, 1, 0);
    checks++; if (a_hit !== 1'b1 || a_load !== 32'h1111_2222) begin errors++;
      $display("FAIL chg_frame1 ihit=%b load=%h want 1/11112222", a_hit, a_load); end
  endtask

  task automatic test_reset_mid_fill();
    step(1, 32'hC, 1, 0);
    step(1, 32'hC, 1, 0);
    checks++; if (a_iren !== 1'b1) begin errors++; $display("FAIL rst_pre_iren got %b want 1", a_iren); end
    @(negedge CLK);
    bus.imemREN = 0; nRST = 1'b0;
    #1;
    checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL rst_async_iren got %b want 0", bus.iREN); end
    model_reset();
    @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    step(1, 32'hC, 1, 0);
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL rst_rehit ihit=%b want 0", a_hit); end
    step(1, 32'hC, 0, 32'h0C0C_0C0C);
    checks++; if (a_mc !== 32'd1 || a_iaddr !== 32'hC) begin errors++;
      $display("FAIL rst_miss_count mc=%0d iaddr=%h want 1/c", a_mc, a_iaddr); end
  endtask

  task automatic test_byte_offset();
    step(1, 32'h10, 1, 0);
    step(1, 32'h10, 0, 32'hCAFE_F00D);
    step(1, 32'h13, 1, 0);
    checks++; if (a_hit !== 1'b1 || a_load !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL byteoff ihit=%b load=%h want 1/cafef00d", a_hit, a_load); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 600; k++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0, $urandom);
      checks++; if (a_hit !== e_hit || a_iren !== e_iren) begin errors++;
        $display("FAIL rnd%0d_ctl ihit=%b iren=%b want %b/%b", k, a_hit, a_iren, e_hit, e_iren); end
      if (e_hit) begin
        checks++; if (a_load !== e_load) begin errors++;
          $display("FAIL rnd%0d_load got %h want %h", k, a_load, e_load); end
      end
      if (e_iren) begin
        checks++; if (a_iaddr !== e_iaddr) begin errors++;
          $display("FAIL rnd%0d_iaddr got %h want %h", k, a_iaddr, e_iaddr); end
      end
    end
    step(0, 32'h0, 0, 0);
    checks++; if (a_hc !== m_hits || a_mc !== m_miss) begin errors++;
      $display("FAIL rnd_counters hc=%0d mc=%0d want %0d/%0d", a_hc, a_mc, m_hits, m_miss); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_eviction();
    test_req_change();
    test_reset_mid_fill();
    test_byte_offset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
